// File: rtl/scoreboard_register_bank_pkg.sv
// Shared constants and helpers for the scoreboard register bank.
// Provides:
//   DEFAULT_N / DEFAULT_DEPTH / DEFAULT_READ_PORTS : default geometry
//   addr_width(depth)     : address width for a given register count
//   zero_reg_index(depth) : index of the hardwired-zero register (XZR)
package scoreboard_register_bank_pkg;

  localparam int DEFAULT_N          = 64;
  localparam int DEFAULT_DEPTH      = 32;
  localparam int DEFAULT_READ_PORTS = 2;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int zero_reg_index(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/scoreboard_register_bank_if.sv
// Bus bundle for the scoreboard register bank.
// master: the issue/writeback side (drives write, reserve and read addresses)
// slave : the register bank (returns read data, readiness, busy and conflict)
//   write / write_address / write_data       : writeback port
//   reserve / reserve_address                : issue-time reservation
//   read_address / read_data / read_ready    : packed read ports, port k at [k*W +: W]
//   busy                                     : pending-write vector
//   reserve_conflict                         : one-cycle pulse, reserve of a busy register
interface scoreboard_register_bank_if
  import scoreboard_register_bank_pkg::*;
#(
  parameter int n          = DEFAULT_N,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int READ_PORTS = DEFAULT_READ_PORTS
);
  localparam int AW = addr_width(DEPTH);

  logic                       write;
  logic [AW-1:0]              write_address;
  logic [n-1:0]               write_data;
  logic                       reserve;
  logic [AW-1:0]              reserve_address;
  logic [READ_PORTS*AW-1:0]   read_address;
  logic [READ_PORTS*n-1:0]    read_data;
  logic [READ_PORTS-1:0]      read_ready;
  logic [DEPTH-1:0]           busy;
  logic                       reserve_conflict;

  modport master (
    output write, write_address, write_data,
    output reserve, reserve_address,
    output read_address,
    input  read_data, read_ready, busy, reserve_conflict
  );

  modport slave (
    input  write, write_address, write_data,
    input  reserve, reserve_address,
    input  read_address,
    output read_data, read_ready, busy, reserve_conflict
  );

endinterface

// File: rtl/scoreboard_busy_tracker.sv
// Pending-write tracker for the scoreboard register bank.
// Ports:
//   clock, reset_n       : clock and async active-low reset
//   write_live           : qualified writeback (legal address, not in reset)
//   write_address        : writeback destination
//   reserve_live         : qualified reservation
//   reserve_address      : register being reserved
//   busy                 : one pending bit per register
//   reserve_conflict     : registered pulse when a still-busy register is reserved again
module scoreboard_busy_tracker
  import scoreboard_register_bank_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             write_live,
  input  logic [AW-1:0]    write_address,
  input  logic             reserve_live,
  input  logic [AW-1:0]    reserve_address,
  output logic [DEPTH-1:0] busy,
  output logic             reserve_conflict
);

  logic [DEPTH-1:0] busy_next;
  logic             conflict_next;

  // Clear for the writeback first so a same-cycle reservation of the same
  // register wins and leaves it pending.
  always_comb begin
    busy_next = busy;
    if (write_live) busy_next[write_address] = 1'b0;
    if (reserve_live) busy_next[reserve_address] = 1'b1;
  end

  // A register being written this cycle is being released, so reserving it
  // again is the normal reuse case, not a conflict.
  assign conflict_next = reserve_live && busy[reserve_address] &&
                         !(write_live && (write_address == reserve_address));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy             <= '0;
      reserve_conflict <= 1'b0;
    end else begin
      busy             <= busy_next;
      reserve_conflict <= conflict_next;
    end
  end

endmodule

// File: rtl/scoreboard_register_bank.sv
// Register bank with issue-time scoreboard.
// Holds DEPTH registers of n bits with READ_PORTS combinational read ports,
// same-cycle writeback bypass and a per-register pending (busy) bit.
// Ports:
//   clock, reset_n : clock and async active-low reset
//   bus (slave)    : writeback, reservation and read ports, busy vector,
//                    reserve_conflict pulse
// With ZERO_REG=1 the last register reads as zero, is always ready, and
// ignores writes and reservations. Addresses >= DEPTH behave the same way.
module scoreboard_register_bank
  import scoreboard_register_bank_pkg::*;
#(
  parameter int n          = DEFAULT_N,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int READ_PORTS = DEFAULT_READ_PORTS,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  scoreboard_register_bank_if.slave bus
);

  localparam int AW   = addr_width(DEPTH);
  localparam int ZIDX = zero_reg_index(DEPTH);

  // True for addresses backed by real, writable storage.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !(ZERO_REG && (int'(a) == ZIDX));
  endfunction

  logic [n-1:0]            regs [DEPTH];
  logic                    write_live;
  logic                    reserve_live;
  logic [DEPTH-1:0]        busy_vec;
  logic                    conflict;
  logic [READ_PORTS*n-1:0] rd_data;
  logic [READ_PORTS-1:0]   rd_ready;
  logic [AW-1:0]           port_addr;

  // Gating with reset_n keeps writes presented during reset out of both the
  // storage and the bypass path.
  assign write_live   = reset_n && bus.write && addr_live(bus.write_address);
  assign reserve_live = reset_n && bus.reserve && addr_live(bus.reserve_address);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_live) begin
      regs[bus.write_address] <= bus.write_data;
    end
  end

  scoreboard_busy_tracker #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_busy_tracker (
    .clock            (clock),
    .reset_n          (reset_n),
    .write_live       (write_live),
    .write_address    (bus.write_address),
    .reserve_live     (reserve_live),
    .reserve_address  (bus.reserve_address),
    .busy             (busy_vec),
    .reserve_conflict (conflict)
  );

  // Dead addresses (zero register, out of range) default to 0 / ready.
  always_comb begin
    rd_data   = '0;
    rd_ready  = '1;
    port_addr = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      port_addr = bus.read_address[k*AW +: AW];
      if (addr_live(port_addr)) begin
        if (write_live && (bus.write_address == port_addr)) begin
          rd_data[k*n +: n] = bus.write_data;
          rd_ready[k]       = 1'b1;
        end else begin
          rd_data[k*n +: n] = regs[port_addr];
          rd_ready[k]       = !busy_vec[port_addr];
        end
      end
    end
  end

  assign bus.read_data        = rd_data;
  assign bus.read_ready       = rd_ready;
  assign bus.busy             = busy_vec;
  assign bus.reserve_conflict = conflict;

endmodule

// File: tb/tb_scoreboard_register_bank.sv
// Self-checking bench for scoreboard_register_bank (default geometry).
module tb_scoreboard_register_bank;

  localparam int N     = 64;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int XZR   = 31;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  scoreboard_register_bank_if bus ();

  scoreboard_register_bank dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Architectural view of the bank.
  logic [N-1:0]     m_regs [DEPTH];
  logic [DEPTH-1:0] m_busy;
  logic             m_conflict;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
    m_busy     = '0;
    m_conflict = 1'b0;
  endtask

  function automatic logic [N-1:0] exp_data(input int a);
    if (a == XZR) return '0;
    if (reset_n && bus.write && int'(bus.write_address) == a) return bus.write_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_ready(input int a);
    if (a == XZR) return 1'b1;
    if (reset_n && bus.write && int'(bus.write_address) == a) return 1'b1;
    return !m_busy[a];
  endfunction

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [N-1:0] wd,
                       input logic r, input logic [AW-1:0] ra,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.write           = w;
    bus.write_address   = wa;
    bus.write_data      = wd;
    bus.reserve         = r;
    bus.reserve_address = ra;
    bus.read_address    = {a1, a0};
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    int  wa, ra;
    logic c;
    @(posedge clock);
    if (reset_n) begin
      wa = int'(bus.write_address);
      ra = int'(bus.reserve_address);
      c = bus.reserve && ra != XZR && m_busy[ra] && !(bus.write && wa == ra);
      if (bus.write && wa != XZR) begin
        m_regs[wa] = bus.write_data;
        m_busy[wa] = 1'b0;
      end
      if (bus.reserve && ra != XZR) m_busy[ra] = 1'b1;
      m_conflict = c;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 5'd0, 5'd5);
    model_clear();
    repeat (2) @(negedge clock);
    total++; if (bus.busy !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", bus.busy); end
    total++; if (bus.reserve_conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got=%b exp=0", bus.reserve_conflict); end
    total++; if (bus.read_ready !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b exp=11", bus.read_ready); end
    total++; if (bus.read_data !== 128'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.read_data); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_write_read();
    drive(1, 5'd5, 64'h1234, 0, 0, 5'd0, 5'd0);
    tick();
    drive(0, 0, 0, 0, 0, 5'd5, 5'd5);
    #1;
    total++; if (bus.read_data[63:0] !== 64'h1234) begin bad++; $display("FAIL wr_rd_p0 got=%h exp=1234", bus.read_data[63:0]); end
    total++; if (bus.read_data[127:64] !== 64'h1234) begin bad++; $display("FAIL wr_rd_p1 got=%h exp=1234", bus.read_data[127:64]); end
    total++; if (bus.read_ready[0] !== 1'b1) begin bad++; $display("FAIL wr_rd_ready got=%b exp=1", bus.read_ready[0]); end
  endtask

  task automatic test_reserve_bypass();
    drive(0, 0, 0, 1, 5'd7, 5'd7, 5'd7);
    tick();
    drive(0, 0, 0, 0, 0, 5'd7, 5'd7);
    #1;
    total++; if (bus.busy[7] !== 1'b1) begin bad++; $display("FAIL rsv_busy got=%b exp=1", bus.busy[7]); end
    total++; if (bus.read_ready !== 2'b00) begin bad++; $display("FAIL rsv_ready got=%b exp=00", bus.read_ready); end
    drive(1, 5'd7, 64'hAA, 0, 0, 5'd7, 5'd7);
    #1;
    total++; if (bus.read_data !== {64'hAA, 64'hAA}) begin bad++; $display("FAIL bypass_data got=%h exp=aa/aa", bus.read_data); end
    total++; if (bus.read_ready !== 2'b11) begin bad++; $display("FAIL bypass_ready got=%b exp=11", bus.read_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 5'd7, 5'd0);
    #1;
    total++; if (bus.busy[7] !== 1'b0) begin bad++; $display("FAIL wb_clear_busy got=%b exp=0", bus.busy[7]); end
    total++; if (bus.read_data[63:0] !== 64'hAA) begin bad++; $display("FAIL wb_stored got=%h exp=aa", bus.read_data[63:0]); end
  endtask

  task automatic test_zero_reg();
    drive(1, 5'd31, 64'hFFFF, 0, 0, 5'd31, 5'd31);
    #1;
    total++; if (bus.read_data[63:0] !== 64'h0) begin bad++; $display("FAIL xzr_nobypass got=%h exp=0", bus.read_data[63:0]); end
    tick();
    drive(0, 0, 0, 1, 5'd31, 5'd31, 5'd31);
    #1;
    total++; if (bus.read_data !== 128'h0) begin bad++; $display("FAIL xzr_data got=%h exp=0", bus.read_data); end
    tick();
    drive(0, 0, 0, 1, 5'd31, 5'd31, 5'd31);
    tick();
    drive(0, 0, 0, 0, 0, 5'd31, 5'd31);
    #1;
    total++; if (bus.busy[31] !== 1'b0) begin bad++; $display("FAIL xzr_busy got=%b exp=0", bus.busy[31]); end
    total++; if (bus.reserve_conflict !== 1'b0) begin bad++; $display("FAIL xzr_conflict got=%b exp=0", bus.reserve_conflict); end
    total++; if (bus.read_ready !== 2'b11) begin bad++; $display("FAIL xzr_ready got=%b exp=11", bus.read_ready); end
  endtask

  task automatic test_conflict();
    drive(0, 0, 0, 1, 5'd3, 5'd3, 5'd0);
    tick();
    total++; if (bus.reserve_conflict !== 1'b0) begin bad++; $display("FAIL first_rsv_conflict got=%b exp=0", bus.reserve_conflict); end
    drive(0, 0, 0, 1, 5'd3, 5'd3, 5'd0);
    tick();
    total++; if (bus.reserve_conflict !== 1'b1) begin bad++; $display("FAIL second_rsv_conflict got=%b exp=1", bus.reserve_conflict); end
    total++; if (bus.busy[3] !== 1'b1) begin bad++; $display("FAIL conflict_busy got=%b exp=1", bus.busy[3]); end
    drive(0, 0, 0, 0, 0, 5'd3, 5'd0);
    tick();
    total++; if (bus.reserve_conflict !== 1'b0) begin bad++; $display("FAIL conflict_pulse_len got=%b exp=0", bus.reserve_conflict); end
    total++; if (bus.busy[3] !== 1'b1) begin bad++; $display("FAIL conflict_busy_held got=%b exp=1", bus.busy[3]); end
    drive(1, 5'd3, 64'h3, 0, 0, 5'd0, 5'd0);
    tick();
  endtask

  task automatic test_same_cycle();
    drive(0, 0, 0, 1, 5'd9, 5'd9, 5'd9);
    tick();
    drive(1, 5'd9, 64'h55, 1, 5'd9, 5'd9, 5'd9);
    tick();
    total++; if (bus.reserve_conflict !== 1'b0) begin bad++; $display("FAIL same_conflict got=%b exp=0", bus.reserve_conflict); end
    total++; if (bus.busy[9] !== 1'b1) begin bad++; $display("FAIL same_busy got=%b exp=1", bus.busy[9]); end
    drive(0, 0, 0, 0, 0, 5'd9, 5'd9);
    #1;
    total++; if (bus.read_data !== {64'h55, 64'h55}) begin bad++; $display("FAIL same_data got=%h exp=55/55", bus.read_data); end
    total++; if (bus.read_ready !== 2'b00) begin bad++; $display("FAIL same_ready got=%b exp=00", bus.read_ready); end
  endtask

  task automatic test_random();
    logic [AW-1:0] wa, ra, a0, a1;
    for (int it = 0; it < 400; it++) begin
      wa = AW'($urandom_range(0, DEPTH-1));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH-1));
      a0 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH-1));
      a1 = ($urandom_range(0, 4) == 0) ? a0 : AW'($urandom_range(0, DEPTH-1));
      drive(1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
            ($urandom_range(0, 9) < 4), ra, a0, a1);
      #1;
      for (int k = 0; k < 2; k++) begin
        int a;
        a = int'(bus.read_address[k*AW +: AW]);
        total++; if (bus.read_data[k*N +: N] !== exp_data(a)) begin bad++; $display("FAIL rnd_data it=%0d port=%0d addr=%0d got=%h exp=%h", it, k, a, bus.read_data[k*N +: N], exp_data(a)); end
        total++; if (bus.read_ready[k] !== exp_ready(a)) begin bad++; $display("FAIL rnd_ready it=%0d port=%0d addr=%0d got=%b exp=%b", it, k, a, bus.read_ready[k], exp_ready(a)); end
      end
      total++; if (bus.busy !== m_busy) begin bad++; $display("FAIL rnd_busy it=%0d got=%h exp=%h", it, bus.busy, m_busy); end
      total++; if (bus.reserve_conflict !== m_conflict) begin bad++; $display("FAIL rnd_conflict it=%0d got=%b exp=%b", it, bus.reserve_conflict, m_conflict); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1, 5'd5, 64'h1234, 1, 5'd2, 5'd0, 5'd0);
    tick();
    drive(0, 0, 0, 0, 0, 5'd5, 5'd2);
    #1;
    total++; if (bus.busy[2] !== 1'b1) begin bad++; $display("FAIL pre_rst_busy got=%b exp=1", bus.busy[2]); end
    #1;
    reset_n = 1'b0;
    #1;
    model_clear();
    total++; if (bus.busy !== 32'h0) begin bad++; $display("FAIL async_busy got=%h exp=0", bus.busy); end
    total++; if (bus.read_data !== 128'h0) begin bad++; $display("FAIL async_data got=%h exp=0", bus.read_data); end
    total++; if (bus.read_ready !== 2'b11) begin bad++; $display("FAIL async_ready got=%b exp=11", bus.read_ready); end
    drive(1, 5'd4, 64'h77, 1, 5'd4, 5'd4, 5'd4);
    #1;
    total++; if (bus.read_data !== 128'h0) begin bad++; $display("FAIL rst_nobypass got=%h exp=0", bus.read_data); end
    tick();
    drive(0, 0, 0, 0, 0, 5'd4, 5'd5);
    reset_n = 1'b1;
    #1;
    total++; if (bus.read_data !== 128'h0) begin bad++; $display("FAIL rst_write_ignored got=%h exp=0", bus.read_data); end
    total++; if (bus.busy !== 32'h0) begin bad++; $display("FAIL rst_reserve_ignored got=%h exp=0", bus.busy); end
    total++; if (bus.read_ready !== 2'b11) begin bad++; $display("FAIL post_rst_ready got=%b exp=11", bus.read_ready); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reserve_bypass();
    test_zero_reg();
    test_conflict();
    test_same_cycle();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/scoreboard_register_bank.md
SCOREBOARD_REGISTER_BANK -- requirements
Module: scoreboard_register_bank

Interface
REQ-001 Parameter n, default 64: data width of every register.
REQ-002 Parameter DEPTH, default 32: number of architectural registers; address width AW = clog2(DEPTH).
REQ-003 Parameter READ_PORTS, default 2: number of independent read ports.
REQ-004 Parameter ZERO_REG, default 1: when 1, register DEPTH-1 is hardwired zero (XZR).
REQ-005 clock  input  1  single clock; all state updates on posedge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 write  input  1  writeback enable.
REQ-008 write_address  input  AW  writeback destination.
REQ-009 write_data  input  n  writeback data.
REQ-010 reserve  input  1  issue-time reservation enable; marks destination pending.
REQ-011 reserve_address  input  AW  register to reserve.
REQ-012 read_address  input  READ_PORTS*AW  packed read addresses; port k occupies bits [k*AW +: AW].
REQ-013 read_data  output  READ_PORTS*n  packed read data, same packing.
REQ-014 read_ready  output  READ_PORTS  bit k = port k operand valid (not pending).
REQ-015 busy  output  DEPTH  current pending-write vector, one bit per register.
REQ-016 reserve_conflict  output  1  registered one-cycle pulse on a reservation of an already-busy register.

Function
REQ-017 Reads are combinational: read_data port k = registers[read_address k], with bypass as follows.
REQ-018 Bypass: when write=1 and write_address equals read_address k, port k shall return write_data in the same cycle.
REQ-019 With ZERO_REG=1, a read of address DEPTH-1 shall return 0 and read_ready=1 regardless of writes or reservations.
REQ-020 A write or reserve targeting DEPTH-1 with ZERO_REG=1 shall be ignored: no storage change, no busy change, no conflict.
REQ-021 A read address >= DEPTH shall return 0 with read_ready=1; a write or reserve address >= DEPTH shall be ignored.
REQ-022 A write shall update the register at the posedge and clear its busy bit at the same posedge.
REQ-023 A reserve shall set the busy bit of reserve_address at the posedge.
REQ-024 When reserve and write target the same register in the same cycle, busy shall remain 1 (the new reservation wins) and the data shall be written.
REQ-025 read_ready k = NOT busy[addr], OR (write=1 AND write_address=addr) (bypass satisfies the operand).
REQ-026 reserve_conflict shall be 1 in the cycle after a reserve to a register whose busy bit was 1 before that posedge and which was not written in that cycle; otherwise 0. The reservation is still applied.
REQ-027 A write to a non-busy register is legal; it updates data and leaves busy at 0.
REQ-028 All read ports are fully independent; identical addresses on several ports return identical data.

Reset
REQ-029 reset_n=0 shall asynchronously clear all registers to 0, busy to all-0, and reserve_conflict to 0.
REQ-030 Reset asserted mid-operation discards pending reservations; after release, every read_ready=1 and every read returns 0 until written.
REQ-031 Writes and reserves presented while reset_n=0 shall have no effect.

Structure
REQ-032 Shared package holds the default n, DEPTH and READ_PORTS constants and the zero-register index function clog2/DEPTH-1.
REQ-033 One sub-module, scoreboard_busy_tracker, owns the busy vector and conflict pulse; storage and bypass stay in the top module.
REQ-034 Storage is a flat register array without an enable gated clock; no read latency.

Verification
REQ-035 Reset, then write r5=0x1234 -> next cycle read port 0 at r5 = 0x1234, read_ready=1.
REQ-036 Reserve r7 -> busy[7]=1 and read_ready=0 for r7; write r7=0xAA the next cycle -> same cycle read returns 0xAA with read_ready=1; after the posedge busy[7]=0.
REQ-037 Write r31=0xFFFF with defaults -> read r31 = 0, busy[31]=0, reserve r31 -> no conflict.
REQ-038 Reserve r3 twice consecutively without a write -> reserve_conflict=1 for exactly one cycle after the second reserve, busy[3] stays 1.
REQ-039 Same cycle reserve r9 and write r9=0x55 (r9 previously busy) -> data 0x55 stored, busy[9]=1, reserve_conflict=0.
REQ-040 Reserve r2, assert reset_n=0 asynchronously mid-cycle -> busy=0 and all data 0 immediately, read_ready all 1.
